mini_bit_tx_capture: RTL and testbench
======================================

Name: mini_bit_tx_capture

Overview:
- Downstream consumer of the MiniBit CPU `tx` serial line.
- Deserialises 8N1 frames, LSB first, and buffers the received bytes in a show-ahead FIFO.
- The bench, or a host-side interface, drains the FIFO with a simple read strobe.
- Sits in the same `clk` domain as the CPU, so `tx` is sampled directly with no synchroniser.

Parameters:
- CLKS_PER_BIT, 16, `clk` cycles per serial bit (C); even, >= 4.
- FIFO_DEPTH, 8, byte entries; power of two, >= 2.
- CNT_W, 4, width of `count`; must satisfy 2^CNT_W > FIFO_DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- reg_clear  in  1  asynchronous, active-high reset.
- tx  in  1  serial line from CPU; idle high.
- rd_en  in  1  pop head of FIFO; ignored when empty.
- clr_err  in  1  clears sticky error flags.
- data_out  out  8  FIFO head byte; valid while empty=0.
- empty  out  1  FIFO holds no bytes.
- full  out  1  FIFO holds FIFO_DEPTH bytes.
- count  out  CNT_W  number of bytes held.
- busy  out  1  receiver not in IDLE.
- frame_err  out  1  sticky; stop bit sampled low.
- overrun  out  1  sticky; completed byte dropped because FIFO full.

Behaviour:
- Reset (async, reg_clear=1):
  - state=IDLE; all counters and pointers 0.
  - empty=1, full=0, count=0, busy=0, frame_err=0, overrun=0, data_out=0.
  - Asserting reset mid-frame or mid-read aborts immediately; no partial byte is kept.
- Receiver FSM, with H = C/2 and E0 = edge at which IDLE sees tx=0:
  - IDLE: on tx=0 go to START, cycle counter cleared.
  - START: at E0+H sample tx. If 1 (glitch), return to IDLE with nothing pushed and no flag set. If 0, go to DATA.
  - DATA: bit i (i=0..7) sampled at E0+H+(i+1)*C into shift register, LSB first.
  - STOP: sampled at E0+H+9*C.
    - If 1: push the byte and go to IDLE.
    - If 0: set frame_err, discard the byte, go to BREAK.
  - BREAK: wait for tx=1, then IDLE. A long low line yields exactly one frame_err and no bytes.
  - busy=1 in every state except IDLE.
- Push timing:
  - Push occurs on the edge of the stop sample.
  - From the following cycle: empty=0, count incremented, data_out = byte if the FIFO was empty.
  - Latency from E0 to byte visible: H+9*C+1 cycles (153 for C=16).
- FIFO:
  - Show-ahead: data_out always reflects the head entry.
  - rd_en with empty=0 advances the head on that edge.
  - Pointers wrap modulo FIFO_DEPTH.
- Push while full:
  - Without rd_en: byte dropped, overrun set, contents unchanged.
  - With rd_en on the same edge: pop and push both succeed; full stays 1; overrun not set.
- Other simultaneous events:
  - Push and rd_en on the same edge while empty=1: push succeeds, rd_en ignored, count becomes 1.
  - Push and pop on the same edge otherwise: count unchanged.
- Sticky flags:
  - frame_err and overrun are cleared only by clr_err or reset.
  - If clr_err coincides with a new error event, the set wins.
- count, full and empty are registered and mutually consistent every cycle.
- A new start bit is accepted the cycle after returning to IDLE. Back-to-back frames with a single stop bit must be received without loss.

Test Plan:
- Single frame 0xA5, C=16, idle high → busy=1 from E0+1; data_out=0xA5, empty=0, count=1 at E0+153; rd_en one cycle → empty=1, count=0.
- Back-to-back frames 0x01, 0x80, 0xFF, 0x00 with no idle gap → FIFO read order 0x01, 0x80, 0xFF, 0x00; frame_err=0, overrun=0.
- Send 9 frames into FIFO_DEPTH=8 with no reads → full=1, count=8 after frame 8; overrun=1 after frame 9; reads return frames 1-8 only.
- Frame 0x3C with stop bit held low for 3*C, then line high, then frame 0x5A → frame_err=1 and no 0x3C in FIFO; 0x5A received; clr_err pulse → frame_err=0.
- Glitch: tx low for 3 cycles then high → back to IDLE at E0+H; empty stays 1; no flags set.
- Reset mid-frame: reg_clear pulse during DATA bit 4 with 2 bytes already queued → all outputs at reset values next cycle; the following complete frame 0x77 is received correctly.

Source files
------------

// File: rtl/mini_bit_tx_capture.sv
// Receives 8N1 bytes (LSB first) from the MiniBit tx line and queues them in
// a show-ahead FIFO drained by a read strobe. Same clock domain as the CPU.
module mini_bit_tx_capture #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             reg_clear,
  input  logic             tx,
  input  logic             rd_en,
  input  logic             clr_err,
  output logic [7:0]       data_out,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [TW-1:0]    T_HALF  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0]    T_FULL  = TW'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tick, tick_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          push;
  logic          stop_bad;

  always_ff @(posedge clk or posedge reg_clear) begin
    if (reg_clear) begin
      state   <= S_IDLE;
      tick    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nx;
      tick    <= tick_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
    end
  end

  // tick counts cycles since the last sample point; samples land mid-bit.
  always_comb begin
    state_nx   = state;
    tick_nx    = tick;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    push       = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      S_IDLE: begin
        tick_nx    = '0;
        bit_idx_nx = '0;
        if (!tx) state_nx = S_START;
      end
      S_START: begin
        if (tick == T_HALF) begin
          tick_nx  = '0;
          state_nx = tx ? S_IDLE : S_DATA;
        end else begin
          tick_nx = tick + 1'b1;
        end
      end
      S_DATA: begin
        if (tick == T_FULL) begin
          tick_nx    = '0;
          shreg_nx   = {tx, shreg[7:1]};
          bit_idx_nx = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_nx = S_STOP;
        end else begin
          tick_nx = tick + 1'b1;
        end
      end
      S_STOP: begin
        if (tick == T_FULL) begin
          tick_nx = '0;
          if (tx) begin
            push     = 1'b1;
            state_nx = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_nx = S_BREAK;
          end
        end else begin
          tick_nx = tick + 1'b1;
        end
      end
      S_BREAK: begin
        if (tx) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // FIFO: a pop on the same edge frees the slot a push into a full FIFO needs.
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [CNT_W-1:0] count_nx;
  logic             pop, push_ok, drop;

  assign pop     = rd_en && !empty;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_comb begin
    count_nx = count;
    if (push_ok && !pop)      count_nx = count + 1'b1;
    else if (!push_ok && pop) count_nx = count - 1'b1;
  end

  always_ff @(posedge clk or posedge reg_clear) begin
    if (reg_clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      count <= count_nx;
      empty <= (count_nx == '0);
      full  <= (count_nx == DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= shreg;
  end

  assign data_out = empty ? 8'h00 : mem[rptr];

  // A new error event on the same edge as clr_err leaves the flag set.
  always_ff @(posedge clk or posedge reg_clear) begin
    if (reg_clear) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (stop_bad)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (drop)         overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mini_bit_tx_capture.sv
// Bench for mini_bit_tx_capture: serial frame driver, queue-based reference
// model of the receive FIFO and sticky flags, directed and random frames.
module tb_mini_bit_tx_capture;

  localparam int C = 16;
  localparam int H = C / 2;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       reg_clear;
  logic       tx;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] data_out;
  logic       empty, full, busy, frame_err, overrun;
  logic [3:0] count;

  mini_bit_tx_capture #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .CNT_W(4)) dut (
    .clk(clk), .reg_clear(reg_clear), .tx(tx), .rd_en(rd_en), .clr_err(clr_err),
    .data_out(data_out), .empty(empty), .full(full), .count(count),
    .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] model_q[$];
  bit         m_ferr = 1'b0;
  bit         m_ovr = 1'b0;
  int         first_vis;
  logic       busy1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(count), 32'(model_q.size()));
    check({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({tag, "_full"}, 32'(full), 32'(model_q.size() == D));
    check({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
    check({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Line level k cycles after the start edge: start bit, 8 data bits LSB first, stop.
  function automatic logic line_level(input logic [7:0] d, input int k, input int stop_low);
    if (k < C) return 1'b0;
    if (k < 9 * C) return d[(k / C) - 1];
    return (stop_low == 0);
  endfunction

  task automatic send_frame(input logic [7:0] d, input int stop_low, input bit rd_at_push);
    int total;
    bit popped;
    total = (stop_low != 0) ? 9 * C + stop_low : 10 * C;
    first_vis = -1;
    busy1 = 1'b0;
    popped = 1'b0;
    for (int k = 0; k < total; k++) begin
      tx = line_level(d, k, stop_low);
      rd_en = rd_at_push && (k == H + 9 * C);
      if (rd_en && model_q.size() > 0) begin
        check("push_rd_head", 32'(data_out), 32'(model_q[0]));
        popped = 1'b1;
      end
      @(negedge clk);
      if (k == 0) busy1 = busy;
      if (first_vis < 0 && !empty) first_vis = k + 1;
    end
    rd_en = 1'b0;
    tx = 1'b1;
    if (popped) void'(model_q.pop_front());
    if (stop_low != 0) m_ferr = 1'b1;
    else if (model_q.size() < D) model_q.push_back(d);
    else m_ovr = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    check({tag, "_data"}, 32'(data_out), 32'(model_q[0]));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    void'(model_q.pop_front());
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_ferr = 1'b0;
    m_ovr = 1'b0;
  endtask

  initial begin
    reg_clear = 1'b1;
    tx = 1'b1;
    rd_en = 1'b0;
    clr_err = 1'b0;
    idle(3);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check_status("rst");
    reg_clear = 1'b0;
    idle(2);
    check_status("post_rst");

    // Single frame: latency and read-out
    send_frame(8'hA5, 0, 1'b0);
    check("lat_busy1", 32'(busy1), 32'h1);
    check("lat_visible", 32'(first_vis), 32'(H + 9 * C + 1));
    check_status("single");
    pop_check("single_pop");
    check_status("single_after");

    // Back-to-back frames with no idle gap
    send_frame(8'h01, 0, 1'b0);
    send_frame(8'h80, 0, 1'b0);
    send_frame(8'hFF, 0, 1'b0);
    send_frame(8'h00, 0, 1'b0);
    check_status("b2b");
    for (int i = 0; i < 4; i++) pop_check("b2b_pop");
    check_status("b2b_drained");

    // Fill to full, then overflow by one
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i * 29 + 3), 0, 1'b0);
      if (i == 8) begin
        check("fill_full", 32'(full), 32'h1);
        check("fill_count", 32'(count), 32'h8);
        check("fill_no_ovr", 32'(overrun), 32'h0);
      end
    end
    check("ovr_set", 32'(overrun), 32'h1);
    check_status("ovr");
    for (int i = 0; i < 8; i++) pop_check("ovr_pop");
    check_status("ovr_drained");
    pulse_clr();
    check_status("ovr_clr");

    // Framing error with long low stop, then a good frame
    send_frame(8'h3C, 3 * C, 1'b0);
    idle(C);
    send_frame(8'h5A, 0, 1'b0);
    check("ferr_set", 32'(frame_err), 32'h1);
    check_status("ferr");
    pop_check("ferr_pop");
    pulse_clr();
    check_status("ferr_clr");

    // Glitch on the start bit
    tx = 1'b0;
    for (int k = 0; k <= H; k++) begin
      if (k == 3) tx = 1'b1;
      @(negedge clk);
      if (k == H - 1) check("glitch_busy_pre", 32'(busy), 32'h1);
      if (k == H) check("glitch_busy_post", 32'(busy), 32'h0);
    end
    check_status("glitch");

    // Push with rd_en on an empty FIFO
    send_frame(8'h3E, 0, 1'b1);
    check_status("push_rd_empty");
    pop_check("push_rd_empty_pop");

    // Full FIFO with rd_en at the push edge
    for (int i = 0; i < 8; i++) send_frame(8'($urandom), 0, 1'b0);
    send_frame(8'hC3, 0, 1'b1);
    check_status("full_push_rd");
    while (model_q.size() > 0) pop_check("full_push_rd_pop");

    // Reset in the middle of data bit 4 with two bytes queued
    send_frame(8'h11, 0, 1'b0);
    send_frame(8'h22, 0, 1'b0);
    for (int k = 0; k < H + 4 * C + 5; k++) begin
      tx = line_level(8'h96, k, 0);
      @(negedge clk);
    end
    reg_clear = 1'b1;
    #1;
    check("midrst_data", 32'(data_out), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    model_q.delete();
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    check_status("midrst");
    @(negedge clk);
    reg_clear = 1'b0;
    tx = 1'b1;
    idle(2);
    check_status("midrst_rel");
    send_frame(8'h77, 0, 1'b0);
    check_status("after_rst");
    pop_check("after_rst_pop");

    // Random traffic
    for (int it = 0; it < 30; it++) begin
      logic [7:0] d;
      int sl;
      int n;
      d = 8'($urandom);
      sl = ($urandom_range(0, 7) == 0) ? C * $urandom_range(1, 3) : 0;
      send_frame(d, sl, 1'($urandom_range(0, 1)));
      if (sl != 0) idle(2);
      else idle($urandom_range(0, 3));
      check_status("rnd");
      n = $urandom_range(0, model_q.size());
      for (int j = 0; j < n; j++) pop_check("rnd_pop");
      if ($urandom_range(0, 4) == 0) begin
        pulse_clr();
        check_status("rnd_clr");
      end
    end
    while (model_q.size() > 0) pop_check("final_pop");
    check_status("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
